jk_latch_driver: RTL and testbench
==================================

# jk_latch_driver

Command-driven front end for the level-sensitive JK latch. It accepts one-at-a-time latch operations over a valid/ready handshake and sequences the latch's J, K and enable inputs with programmable setup, pulse and hold phases, so J/K are never changing while enable is high. It keeps a registered model of the latch state. It resolves toggle requests into an explicit set or clear, so the latch never sees J=K=1 with enable high. The latch's reset input is tied to the same `reset` as this block.

## Interface
- `SETUP_CYC`, default 1: cycles J/K are driven before enable rises; legal range 1..15.
- `PULSE_CYC`, default 2: cycles enable is held high; legal range 1..15.
- `HOLD_CYC`, default 1: cycles J/K are held after enable falls; legal range 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_op`  in  2  operation: 00 hold, 01 clear, 10 set, 11 toggle.
- `cmd_ready`  out  1  block can accept a command.
- `j`  out  1  latch J input.
- `k`  out  1  latch K input.
- `enable`  out  1  latch enable.
- `busy`  out  1  a sequence is in progress (state is not IDLE).
- `done`  out  1  one-cycle pulse marking completion of a command.
- `q_model`  out  1  expected latch Q after the last completed command.

## Operation
- States: IDLE, SETUP, PULSE, HOLD. A 4-bit phase counter times each phase.
- Reset state: IDLE. While reset is active, j, k, enable, busy, done, q_model and cmd_ready are all 0.
- Reset mid-sequence:
  - The command in flight is dropped, the state returns to IDLE and all outputs clear on the next edge.
  - No done pulse is produced for the dropped command.
- cmd_ready is (state==IDLE) and !reset.
- A command is accepted on an edge where cmd_valid and cmd_ready are both high. cmd_op is captured only on that edge.
- Resolution at accept:
  - clear: J=0, K=1.
  - set: J=1, K=0.
  - toggle: if q_model is 1, J=0, K=1; otherwise J=1, K=0.
  - hold: no latch activity.
- Sequencing for clear/set/toggle:
  - IDLE → SETUP with the resolved J/K registered.
  - SETUP for SETUP_CYC cycles, then PULSE.
  - PULSE for PULSE_CYC cycles with enable=1, then HOLD.
  - HOLD for HOLD_CYC cycles with enable=0 and J/K unchanged, then IDLE.
- On the return to IDLE: j=k=0, done=1 for one cycle, and q_model is updated to the resolved value.
- Hold op: the state stays IDLE. done=1 on the next cycle. j, k, enable and q_model are unchanged.
- Invariants:
  - j and k are never both 1.
  - j and k change only in cycles where enable is 0.
  - enable is high only in PULSE.
- cmd_valid while busy is ignored. The upstream must hold the command until it is accepted; its value is not sampled while busy.

## Timing
- All outputs are registered except cmd_ready.
- Accept edge at the end of cycle t0, then:
  - J/K valid at t1.
  - enable high from t1+SETUP_CYC for PULSE_CYC cycles.
  - done and the q_model update at t0+1+SETUP_CYC+PULSE_CYC+HOLD_CYC.
- Defaults give done at t5.
- Back-to-back: cmd_ready is 1 in the done cycle, so the next command can be accepted there.
  - Throughput for clear/set/toggle is one command per SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles.
  - Hold ops can be accepted every cycle.

## Structure
- Shared package `jk_drv_pkg`:
  - op encoding constants `OP_HOLD`, `OP_CLR`, `OP_SET`, `OP_TOG`.
  - state enum `jk_drv_state_t`.
  - `PHASE_CNT_W=4`.
- One sub-module, `jk_phase_cnt`: a loadable down-counter with a `last` flag. The FSM loads it with N-1 on entry to each phase.
- Top level: FSM, op resolver, q_model register.

## Test plan
- Defaults; reset for 2 cycles; set accepted at t0:
  - j=1, k=0 over t1..t4; enable=1 at t2..t3.
  - done=1 and q_model=1 at t5; j=k=0 at t5.
- q_model=1, toggle accepted:
  - Resolves to j=0, k=1; q_model=0 after done.
  - Assert j&k never both 1 and no J/K change while enable=1, checked throughout.
- cmd_valid held high with set then clear:
  - cmd_ready=0 during t1..t4.
  - Clear accepted in the done cycle t5; its enable pulse at t7..t8.
- Hold op at t0 with q_model=1:
  - done=1 at t1; enable never rises; q_model stays 1.
- Reset asserted during PULSE:
  - Next cycle j=k=enable=busy=done=q_model=0.
  - No done pulse for the dropped command; cmd_ready=1 the cycle after reset deasserts.
- SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2, clear:
  - enable high only at t4; done at t7.

Source files
------------

// File: rtl/jk_drv_pkg.sv
// Shared definitions for the JK latch driver: op encoding, FSM states, resolver.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package jk_drv_pkg;

    // Width of the per-phase down-counter; phases last 1..15 cycles.
    localparam int PHASE_CNT_W = 4;

    // Command operation encoding on cmd_op.
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TOG  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } jk_drv_state_t;

    // Resolved latch drive for one command. active=0 means no latch activity.
    typedef struct packed {
        logic j;
        logic k;
        logic active;
    } jk_res_t;

    // Toggle is turned into an explicit set or clear against the current
    // model state, so the latch is never driven with J=K=1.
    function automatic jk_res_t resolve_op(input logic [1:0] op, input logic q);
        jk_res_t r;
        r.j      = 1'b0;
        r.k      = 1'b0;
        r.active = 1'b1;
        case (op)
            OP_CLR: begin
                r.j = 1'b0;
                r.k = 1'b1;
            end
            OP_SET: begin
                r.j = 1'b1;
                r.k = 1'b0;
            end
            OP_TOG: begin
                r.j = ~q;
                r.k = q;
            end
            default: begin
                r.active = 1'b0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_phase_cnt.sv
// Loadable phase down-counter; last flags the final cycle of a phase.
// Latency: load takes effect on the next edge; last is combinational from count.
// Backpressure: none; load has priority over decrement, count saturates at 0.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset (count -> 0)
//   load        : load load_val on the next edge (phase entry, value N-1)
//   load_val    : phase length minus one
//   last        : count is zero, i.e. this is the final cycle of the phase
module jk_phase_cnt
    import jk_drv_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [PHASE_CNT_W-1:0] load_val,
    output logic                   last
);

    logic [PHASE_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/jk_latch_driver.sv
// Command front end sequencing J/K/enable of a level-sensitive JK latch.
// Latency: done at accept+1+SETUP_CYC+PULSE_CYC+HOLD_CYC (hold op: accept+1).
// Backpressure: cmd_ready low whenever not IDLE or in reset; one command at a time.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op : command handshake (00 hold, 01 clr, 10 set, 11 tog)
//   j, k, enable      : registered latch drive
//   busy              : a set/clear/toggle sequence is in progress
//   done              : one-cycle completion pulse
//   q_model           : expected latch Q after the last completed command
// Phase lengths SETUP_CYC, PULSE_CYC, HOLD_CYC are each legal in 1..15.
module jk_latch_driver
    import jk_drv_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       j,
    output logic       k,
    output logic       enable,
    output logic       busy,
    output logic       done,
    output logic       q_model
);

    // Counter values loaded on phase entry: a phase of N cycles loads N-1.
    localparam logic [PHASE_CNT_W-1:0] SETUP_LD = PHASE_CNT_W'(SETUP_CYC - 1);
    localparam logic [PHASE_CNT_W-1:0] PULSE_LD = PHASE_CNT_W'(PULSE_CYC - 1);
    localparam logic [PHASE_CNT_W-1:0] HOLD_LD  = PHASE_CNT_W'(HOLD_CYC - 1);

    jk_drv_state_t          state;
    jk_res_t                res;
    logic                   accept;
    logic                   cnt_load;
    logic [PHASE_CNT_W-1:0] cnt_val;
    logic                   cnt_last;

    assign cmd_ready = (state == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;

    // Resolution uses the q_model as it stands at the accept edge.
    assign res = resolve_op(cmd_op, q_model);

    // Phase timer load: on entry to SETUP, PULSE and HOLD.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = SETUP_LD;
        case (state)
            IDLE: begin
                if (accept && res.active) begin
                    cnt_load = 1'b1;
                    cnt_val  = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt_last) begin
                    cnt_load = 1'b1;
                    cnt_val  = PULSE_LD;
                end
            end
            PULSE: begin
                if (cnt_last) begin
                    cnt_load = 1'b1;
                    cnt_val  = HOLD_LD;
                end
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    jk_phase_cnt u_phase_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .last     (cnt_last)
    );

    // J/K are only written on IDLE->SETUP and HOLD->IDLE, both with enable
    // low, so they can never move while the latch is transparent.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            j       <= 1'b0;
            k       <= 1'b0;
            enable  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            q_model <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (res.active) begin
                            state <= SETUP;
                            j     <= res.j;
                            k     <= res.k;
                            busy  <= 1'b1;
                        end else begin
                            // Hold op: no latch activity, just acknowledge.
                            done <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_last) begin
                        state  <= PULSE;
                        enable <= 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_last) begin
                        state  <= HOLD;
                        enable <= 1'b0;
                    end
                end
                HOLD: begin
                    if (cnt_last) begin
                        state   <= IDLE;
                        j       <= 1'b0;
                        k       <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        // J=1 means the resolved command was a set.
                        q_model <= j;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_latch_driver.sv
// Randomized bench for jk_latch_driver with a scoreboard on done pulses.
// Two instances: default phases (1/2/1) and 3/1/2.
module tb_jk_latch_driver;
    import jk_drv_pkg::*;

    localparam int NCYC       = 2400;
    localparam int LAST       = NCYC - 2;
    localparam int STOP_ISSUE = LAST - 40;

    typedef struct {
        int cyc;
        bit q;
    } sb_t;

    logic       clk;
    logic [1:0] rst;
    logic [1:0] vld;
    logic [1:0] op0, op1;
    logic [1:0] rdy, jo, ko, en, bsy, dn, qm;

    int  cyc;
    int  n_vec;
    int  n_bad;
    sb_t sb0[$];
    sb_t sb1[$];

    bit exp_rdy  [2][NCYC];
    bit exp_j    [2][NCYC];
    bit exp_k    [2][NCYC];
    bit exp_en   [2][NCYC];
    bit exp_busy [2][NCYC];
    bit exp_q    [2][NCYC];

    jk_latch_driver #(.SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut0 (
        .clk(clk), .reset(rst[0]), .cmd_valid(vld[0]), .cmd_op(op0),
        .cmd_ready(rdy[0]), .j(jo[0]), .k(ko[0]), .enable(en[0]),
        .busy(bsy[0]), .done(dn[0]), .q_model(qm[0])
    );

    jk_latch_driver #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) dut1 (
        .clk(clk), .reset(rst[1]), .cmd_valid(vld[1]), .cmd_op(op1),
        .cmd_ready(rdy[1]), .j(jo[1]), .k(ko[1]), .enable(en[1]),
        .busy(bsy[1]), .done(dn[1]), .q_model(qm[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int s_of(int i); return (i == 0) ? 1 : 3; endfunction
    function automatic int p_of(int i); return (i == 0) ? 2 : 1; endfunction
    function automatic int h_of(int i); return (i == 0) ? 1 : 2; endfunction

    function automatic int sb_n(int i);
        return (i == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic sb_t sb_front(int i);
        return (i == 0) ? sb0[0] : sb1[0];
    endfunction

    task automatic sb_pop(int i);
        if (i == 0) void'(sb0.pop_front());
        else        void'(sb1.pop_front());
    endtask

    task automatic sb_push(int i, sb_t e);
        if (i == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    // Entries are in completion order, so dropped ones sit at the back.
    task automatic sb_drop_after(int i, int n);
        if (i == 0) begin
            while (sb0.size() > 0 && sb0[sb0.size()-1].cyc > n) void'(sb0.pop_back());
        end else begin
            while (sb1.size() > 0 && sb1[sb1.size()-1].cyc > n) void'(sb1.pop_back());
        end
    endtask

    task automatic set_op(int i, logic [1:0] v);
        if (i == 0) op0 = v;
        else        op1 = v;
    endtask

    task automatic chk(string name, int i, logic act, logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d cyc %0d: got %b want %b", name, i, cyc, act, exp);
        end
    endtask

    task automatic chk_int(string name, int i, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s inst%0d cyc %0d: got %0d want %0d", name, i, cyc, act, exp);
        end
    endtask

    // Directed prefix per instance, then random ops.
    task automatic next_cmd(int i, int idx, output logic [1:0] op, output int gap);
        op  = 2'($urandom_range(0, 3));
        gap = $urandom_range(0, 3);
        if (i == 0) begin
            case (idx)
                0: begin op = OP_SET;  gap = 1; end
                1: begin op = OP_TOG;  gap = 1; end
                2: begin op = OP_SET;  gap = 0; end
                3: begin op = OP_CLR;  gap = 2; end
                4: begin op = OP_SET;  gap = 1; end
                5: begin op = OP_HOLD; gap = 2; end
                6: begin op = OP_SET;  gap = 3; end
                default: ;
            endcase
        end else begin
            case (idx)
                0: begin op = OP_CLR;  gap = 1; end
                1: begin op = OP_SET;  gap = 0; end
                2: begin op = OP_TOG;  gap = 2; end
                3: begin op = OP_HOLD; gap = 0; end
                4: begin op = OP_HOLD; gap = 0; end
                default: ;
            endcase
        end
    endtask

    // Stimulus and reference model.
    initial begin
        int         free_at[2];
        int         next_issue[2];
        bit         want_v[2];
        logic [1:0] want_op[2];
        int         want_gap[2];
        int         cur_idx[2];
        int         idx[2];
        bit         q_m[2];
        int         rst_at;
        bit         rst_now;
        bit         tgt;
        int         len;
        sb_t        e;

        n_vec  = 0;
        n_bad  = 0;
        cyc    = 0;
        rst    = 2'b11;
        vld    = 2'b00;
        op0    = 2'b00;
        op1    = 2'b00;
        rst_at = -100;
        for (int i = 0; i < 2; i++) begin
            free_at[i]    = 1;
            next_issue[i] = 2;
            want_v[i]     = 1'b0;
            want_op[i]    = 2'b00;
            want_gap[i]   = 0;
            cur_idx[i]    = 0;
            idx[i]        = 0;
            q_m[i]        = 1'b0;
        end

        while (cyc < LAST) begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < 2; i++) begin
                rst_now = (cyc < 2) || (i == 0 && cyc >= rst_at && cyc <= rst_at + 1);
                rst[i]  = rst_now;
                if (rst_now) begin
                    exp_rdy[i][cyc] = 1'b0;
                    vld[i]          = 1'b0;
                    set_op(i, 2'($urandom));
                    want_v[i]       = 1'b0;
                    q_m[i]          = 1'b0;
                    free_at[i]      = cyc + 1;
                    for (int c = cyc + 1; c < NCYC; c++) begin
                        exp_j[i][c]    = 1'b0;
                        exp_k[i][c]    = 1'b0;
                        exp_en[i][c]   = 1'b0;
                        exp_busy[i][c] = 1'b0;
                        exp_q[i][c]    = 1'b0;
                    end
                    sb_drop_after(i, cyc);
                    if (next_issue[i] <= cyc) next_issue[i] = cyc + 1;
                end else begin
                    if (!want_v[i] && cyc >= next_issue[i] && cyc < STOP_ISSUE) begin
                        next_cmd(i, idx[i], want_op[i], want_gap[i]);
                        cur_idx[i] = idx[i];
                        idx[i]++;
                        want_v[i] = 1'b1;
                    end
                    exp_rdy[i][cyc] = (cyc >= free_at[i]);
                    vld[i] = want_v[i];
                    set_op(i, want_v[i] ? want_op[i] : 2'($urandom));
                    if (want_v[i] && cyc >= free_at[i]) begin
                        if (want_op[i] == OP_HOLD) begin
                            e.cyc = cyc + 1;
                            e.q   = q_m[i];
                            sb_push(i, e);
                            free_at[i] = cyc + 1;
                        end else begin
                            if (want_op[i] == OP_SET)      tgt = 1'b1;
                            else if (want_op[i] == OP_CLR) tgt = 1'b0;
                            else                           tgt = ~q_m[i];
                            len = s_of(i) + p_of(i) + h_of(i);
                            for (int c = cyc + 1; c <= cyc + len && c < NCYC; c++) begin
                                exp_j[i][c]    = tgt;
                                exp_k[i][c]    = ~tgt;
                                exp_busy[i][c] = 1'b1;
                                exp_en[i][c]   = (c >= cyc + 1 + s_of(i)) &&
                                                 (c <= cyc + s_of(i) + p_of(i));
                            end
                            for (int c = cyc + 1 + len; c < NCYC; c++) exp_q[i][c] = tgt;
                            e.cyc = cyc + 1 + len;
                            e.q   = tgt;
                            sb_push(i, e);
                            q_m[i]     = tgt;
                            free_at[i] = cyc + 1 + len;
                            // Drop this command with a reset in its first PULSE cycle.
                            if (i == 0 && cur_idx[i] == 6) rst_at = cyc + 1 + s_of(i);
                        end
                        want_v[i]     = 1'b0;
                        next_issue[i] = cyc + 1 + want_gap[i];
                    end
                end
            end
        end

        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) chk_int("sb_drained", i, sb_n(i), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Monitor: per-cycle output checks plus scoreboard on done.
    initial begin
        logic pj[2];
        logic pk[2];
        sb_t  e;
        pj[0] = 1'b0; pj[1] = 1'b0;
        pk[0] = 1'b0; pk[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc >= 1 && cyc <= LAST) begin
                for (int i = 0; i < 2; i++) begin
                    chk("cmd_ready", i, rdy[i], exp_rdy[i][cyc]);
                    chk("j",         i, jo[i],  exp_j[i][cyc]);
                    chk("k",         i, ko[i],  exp_k[i][cyc]);
                    chk("enable",    i, en[i],  exp_en[i][cyc]);
                    chk("busy",      i, bsy[i], exp_busy[i][cyc]);
                    chk("q_model",   i, qm[i],  exp_q[i][cyc]);
                    chk("jk_excl",   i, jo[i] & ko[i], 1'b0);
                    if (en[i] === 1'b1 && cyc > 1) begin
                        chk("j_stable_en", i, jo[i], pj[i]);
                        chk("k_stable_en", i, ko[i], pk[i]);
                    end
                    pj[i] = jo[i];
                    pk[i] = ko[i];
                    while (sb_n(i) > 0 && sb_front(i).cyc < cyc) begin
                        e = sb_front(i);
                        n_vec++;
                        n_bad++;
                        $display("FAIL done_missing inst%0d cyc %0d: got no done want done at %0d",
                                 i, cyc, e.cyc);
                        sb_pop(i);
                    end
                    if (dn[i] !== 1'b0) begin
                        if (sb_n(i) == 0) begin
                            n_vec++;
                            n_bad++;
                            $display("FAIL done_unexpected inst%0d cyc %0d: got done=%b want 0",
                                     i, cyc, dn[i]);
                        end else begin
                            e = sb_front(i);
                            sb_pop(i);
                            chk_int("done_cycle", i, cyc, e.cyc);
                            chk("done_q", i, qm[i], e.q);
                        end
                    end
                end
            end
        end
    end

endmodule
